// File: rtl/hdlc_tx_framer.sv
// Bit-serial HDLC transmit framer: opening flag, zero-stuffed payload, closing flag,
// plus abort generation on request or data underrun. One line bit per clock, LSB first.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | line idles at 1, waiting for Tx_DataValid to open a frame
// S_START    | opening flag 0111_1110 on Tx, first byte loaded on bit 7
// S_DATA     | payload bits with zero insertion after five 1s
// S_END      | closing flag on Tx, Tx_Done on its last bit
// S_ABORT    | abort pattern 0 then seven 1s, Tx_ValidFrame low
module hdlc_tx_framer (
   input  logic       Clk,
   input  logic       Rst,
   input  logic [7:0] Tx_Data,
   input  logic       Tx_DataValid,
   input  logic       Tx_DataLast,
   output logic       Tx_DataReady,
   input  logic       Tx_AbortFrame,
   output logic       Tx,
   output logic       Tx_ValidFrame,
   output logic       Tx_AbortedTrans,
   output logic       Tx_Underrun,
   output logic       Tx_Done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_END,
      S_ABORT
   } state_t;

   localparam logic [7:0] FLAG = 8'h7E;

   state_t     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] shreg_q, shreg_d;
   logic       last_q, last_d;
   logic [2:0] ones_q, ones_d;
   logic       stuff_q, stuff_d;
   logic       tx_q, tx_d;
   logic       rdy_q, rdy_d;
   logic       vf_q, vf_d;
   logic       ab_q, ab_d;
   logic       ur_q, ur_d;
   logic       done_q, done_d;

   logic [2:0] cnt_inc;
   logic [2:0] ones_nxt;
   logic [2:0] ones_base;
   logic       nxt_bit;
   logic       do_load;
   logic       do_abort;
   logic       do_underrun;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shreg_d     = shreg_q;
      last_d      = last_q;
      ones_d      = ones_q;
      stuff_d     = stuff_q;
      tx_d        = 1'b1;
      rdy_d       = 1'b0;
      vf_d        = 1'b0;
      ab_d        = 1'b0;
      ur_d        = 1'b0;
      done_d      = 1'b0;
      cnt_inc     = cnt_q + 3'd1;
      ones_nxt    = 3'd0;
      nxt_bit     = 1'b0;
      do_load     = 1'b0;
      do_abort    = 1'b0;
      do_underrun = 1'b0;
      ones_base   = (state_q == S_DATA) ? ones_q : 3'd0;

      case (state_q)
         S_IDLE: begin
            if (Tx_DataValid) begin
               state_d = S_START;
               cnt_d   = 3'd0;
               tx_d    = FLAG[0];
               vf_d    = 1'b1;
            end
         end
         S_START: begin
            if (Tx_AbortFrame) begin
               do_abort = 1'b1;
            end else if (cnt_q != 3'd7) begin
               cnt_d = cnt_inc;
               tx_d  = FLAG[cnt_inc];
               vf_d  = 1'b1;
               rdy_d = (cnt_q == 3'd6);
            end else if (Tx_DataValid) begin
               do_load = 1'b1;
            end else begin
               do_underrun = 1'b1;
            end
         end
         S_DATA: begin
            if (Tx_AbortFrame) begin
               do_abort = 1'b1;
            end else if (!stuff_q && ones_q == 3'd5) begin
               tx_d    = 1'b0;
               stuff_d = 1'b1;
               ones_d  = 3'd0;
               vf_d    = 1'b1;
               rdy_d   = (cnt_q == 3'd7) && !last_q;
            end else if (cnt_q != 3'd7) begin
               nxt_bit  = shreg_q[cnt_inc];
               ones_nxt = nxt_bit ? ones_q + 3'd1 : 3'd0;
               cnt_d    = cnt_inc;
               tx_d     = nxt_bit;
               ones_d   = ones_nxt;
               stuff_d  = 1'b0;
               vf_d     = 1'b1;
               // Bit 7 is the final slot only if it does not trigger a stuffed 0.
               rdy_d    = (cnt_q == 3'd6) && (ones_nxt != 3'd5) && !last_q;
            end else if (last_q) begin
               state_d = S_END;
               cnt_d   = 3'd0;
               stuff_d = 1'b0;
               tx_d    = FLAG[0];
               vf_d    = 1'b1;
            end else if (Tx_DataValid) begin
               do_load = 1'b1;
            end else begin
               do_underrun = 1'b1;
            end
         end
         S_END: begin
            if (cnt_q != 3'd7) begin
               cnt_d  = cnt_inc;
               tx_d   = FLAG[cnt_inc];
               vf_d   = 1'b1;
               done_d = (cnt_q == 3'd6);
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ABORT: begin
            if (cnt_q != 3'd7) begin
               cnt_d = cnt_inc;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (do_load) begin
         state_d = S_DATA;
         shreg_d = Tx_Data;
         last_d  = Tx_DataLast;
         cnt_d   = 3'd0;
         stuff_d = 1'b0;
         tx_d    = Tx_Data[0];
         ones_d  = Tx_Data[0] ? ones_base + 3'd1 : 3'd0;
         vf_d    = 1'b1;
      end

      if (do_abort || do_underrun) begin
         state_d = S_ABORT;
         cnt_d   = 3'd0;
         stuff_d = 1'b0;
         ones_d  = 3'd0;
         tx_d    = 1'b0;
         ab_d    = 1'b1;
         ur_d    = do_underrun;
         vf_d    = 1'b0;
         rdy_d   = 1'b0;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 3'd0;
         shreg_q <= 8'd0;
         last_q  <= 1'b0;
         ones_q  <= 3'd0;
         stuff_q <= 1'b0;
         tx_q    <= 1'b1;
         rdy_q   <= 1'b0;
         vf_q    <= 1'b0;
         ab_q    <= 1'b0;
         ur_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         last_q  <= last_d;
         ones_q  <= ones_d;
         stuff_q <= stuff_d;
         tx_q    <= tx_d;
         rdy_q   <= rdy_d;
         vf_q    <= vf_d;
         ab_q    <= ab_d;
         ur_q    <= ur_d;
         done_q  <= done_d;
      end
   end

   assign Tx              = tx_q;
   assign Tx_DataReady    = rdy_q;
   assign Tx_ValidFrame   = vf_q;
   assign Tx_AbortedTrans = ab_q;
   assign Tx_Underrun     = ur_q;
   assign Tx_Done         = done_q;

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// Directed bench for hdlc_tx_framer: a bit-level model fills a queue of expected
// per-cycle outputs {Tx, ValidFrame, Ready, Done, AbortedTrans, Underrun}.
module tb_hdlc_tx_framer;

   logic       Clk = 1'b0;
   logic       Rst = 1'b0;
   logic [7:0] Tx_Data = 8'h00;
   logic       Tx_DataValid = 1'b0;
   logic       Tx_DataLast = 1'b0;
   logic       Tx_DataReady;
   logic       Tx_AbortFrame = 1'b0;
   logic       Tx;
   logic       Tx_ValidFrame;
   logic       Tx_AbortedTrans;
   logic       Tx_Underrun;
   logic       Tx_Done;

   hdlc_tx_framer dut (
      .Clk             (Clk),
      .Rst             (Rst),
      .Tx_Data         (Tx_Data),
      .Tx_DataValid    (Tx_DataValid),
      .Tx_DataLast     (Tx_DataLast),
      .Tx_DataReady    (Tx_DataReady),
      .Tx_AbortFrame   (Tx_AbortFrame),
      .Tx              (Tx),
      .Tx_ValidFrame   (Tx_ValidFrame),
      .Tx_AbortedTrans (Tx_AbortedTrans),
      .Tx_Underrun     (Tx_Underrun),
      .Tx_Done         (Tx_Done)
   );

   always #5 Clk = ~Clk;

   logic [5:0] exp_q[$];
   logic [7:0] bytes[8];
   logic [7:0] flag_v;
   int         tests = 0;
   int         fails = 0;

   function automatic logic [5:0] observe();
      return {Tx, Tx_ValidFrame, Tx_DataReady, Tx_Done, Tx_AbortedTrans, Tx_Underrun};
   endfunction

   function void push(input logic tx, input logic vf, input logic rdy,
                      input logic done, input logic ab, input logic ur);
      exp_q.push_back({tx, vf, rdy, done, ab, ur});
   endfunction

   // mode 0: normal frame, 1: underrun after n bytes, 2: abort after k cycles
   function void build(input int n, input int mode, input int k);
      int ones;
      logic [7:0] b;
      ones = 0;
      for (int i = 0; i < 8; i++) push(flag_v[i], 1'b1, (i == 7), 1'b0, 1'b0, 1'b0);
      for (int j = 0; j < n; j++) begin
         b = bytes[j];
         for (int i = 0; i < 8; i++) begin
            push(b[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            ones = b[i] ? ones + 1 : 0;
            if (ones == 5) begin
               push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
               ones = 0;
            end
         end
         if (!(mode == 0 && j == n - 1))
            exp_q[exp_q.size() - 1] = exp_q[exp_q.size() - 1] | 6'b001000;
      end
      if (mode == 0) begin
         for (int i = 0; i < 8; i++) push(flag_v[i], 1'b1, 1'b0, (i == 7), 1'b0, 1'b0);
      end else begin
         if (mode == 2) while (exp_q.size() > k) void'(exp_q.pop_back());
         push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, (mode == 1));
         for (int i = 0; i < 7; i++) push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
   endfunction

   task automatic check_idle(input string tag);
      logic [5:0] obs;
      obs = observe();
      tests++;
      assert (obs === 6'b100000) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, 6'b100000);
      end
   endtask

   task automatic run(input int n, input int mode, input int k, input bit check_runs);
      int idx, cyc, total, run_len, max_run;
      bit adv;
      logic [5:0] e, obs;
      build(n, mode, k);
      total = exp_q.size();
      idx = 0; cyc = 0; adv = 0; run_len = 0; max_run = 0;
      @(negedge Clk);
      Tx_Data      = bytes[0];
      Tx_DataLast  = (mode == 0 && n == 1);
      Tx_DataValid = 1'b1;
      while (exp_q.size() > 0) begin
         @(negedge Clk);
         cyc++;
         if (adv) begin
            idx++;
            if (idx < n) begin
               Tx_Data     = bytes[idx];
               Tx_DataLast = (mode == 0 && idx == n - 1);
            end else begin
               Tx_DataValid = 1'b0;
               Tx_DataLast  = 1'b0;
            end
         end
         Tx_AbortFrame = (mode == 2 && cyc == k);
         if (mode == 2 && cyc == k + 1) Tx_DataValid = 1'b0;
         e   = exp_q.pop_front();
         obs = observe();
         tests++;
         assert (obs === e) else begin
            fails++;
            $error("FAIL stream mode=%0d cyc=%0d observed=%b expected=%b", mode, cyc, obs, e);
         end
         adv = Tx_DataReady;
         if (cyc > 8 && cyc <= total - 8) begin
            run_len = Tx ? run_len + 1 : 0;
            if (run_len > max_run) max_run = run_len;
         end
      end
      Tx_DataValid  = 1'b0;
      Tx_AbortFrame = 1'b0;
      @(negedge Clk);
      check_idle("post_frame_idle");
      if (check_runs) begin
         tests++;
         assert (max_run <= 5) else begin
            fails++;
            $error("FAIL payload_ones_run observed=%0d expected<=5", max_run);
         end
      end
   endtask

   initial begin
      flag_v = 8'h7E;
      repeat (3) @(negedge Clk);
      check_idle("reset_state");
      Rst = 1'b1;
      @(negedge Clk);
      check_idle("idle_after_release");

      bytes[0] = 8'h00;
      run(1, 0, 0, 1'b0);

      bytes[0] = 8'hFF;
      run(1, 0, 0, 1'b0);

      bytes[0] = 8'h7E; bytes[1] = 8'h3F;
      run(2, 0, 0, 1'b1);

      bytes[0] = 8'hA5; bytes[1] = 8'hC3; bytes[2] = 8'h0F;
      run(3, 2, 12, 1'b0);

      bytes[0] = 8'h55;
      run(1, 1, 0, 1'b0);

      // reset in the middle of the opening flag
      @(negedge Clk);
      Tx_Data = 8'h81; Tx_DataLast = 1'b1; Tx_DataValid = 1'b1;
      repeat (4) @(negedge Clk);
      Rst = 1'b0; Tx_DataValid = 1'b0; Tx_DataLast = 1'b0;
      @(negedge Clk);
      check_idle("reset_mid_flag");
      Rst = 1'b1;
      @(negedge Clk);
      check_idle("idle_after_mid_reset");
      bytes[0] = 8'h81;
      run(1, 0, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
